// File: rtl/mips_env_pkg.sv
// Shared definitions for the MIPS run-controller environment.
//   run_state_t : run-controller FSM state encoding (3 bits)
//   CTR_W       : width of the shared hold/stagger down-counter
package mips_env_pkg;

    localparam int CTR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } run_state_t;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the
// second rising clock edge after the input is released.
//   clk         : destination clock
//   async_rst_n : active-low asynchronous reset input
//   sync_rst_n  : active-low reset, deassertion aligned to clk
module reset_sync (
    input  logic clk,
    input  logic async_rst_n,
    output logic sync_rst_n
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= 1'b1;
            sync_reg <= meta_reg;
        end
    end

    assign sync_rst_n = sync_reg;

endmodule

// File: rtl/mips_run_controller.sv
// Run controller for one or more MIPSpipeline cores: holds all core resets
// asserted, releases them one by one with a fixed stagger, counts run cycles
// against a programmable budget, then freezes the cores and flags completion.
//   clk         : single clock, all state on rising edge
//   reset       : asynchronous active-low reset (synchronised release)
//   start       : begin a run (accepted in IDLE and DONE)
//   halt_req    : end the run early (accepted in HOLD, RELEASE, RUN)
//   cycle_limit : run budget in cycles, 0 = unlimited, latched on start
//   ch_rst      : active-high reset per downstream core
//   running     : high while in RUN
//   done        : high while in DONE
//   cycle_count : RUN cycles elapsed in the current/last run (saturating)
module mips_run_controller
    import mips_env_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [CNT_W-1:0]  cycle_limit,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [CTR_W-1:0]  HOLD_LOAD = CTR_W'(HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0]  STAG_LOAD = (STAGGER == 0) ? '0 : CTR_W'(STAGGER - 1);
    localparam logic [NUM_CH-1:0] ALL_RST   = '1;
    // First RELEASE cycle frees channel 0, or every channel when there is no stagger.
    localparam logic [NUM_CH-1:0] FIRST_REL = (STAGGER == 0) ? '0 : (ALL_RST << 1);

    logic              rst_sync_n;
    run_state_t        state_reg, state_next;
    logic [CTR_W-1:0]  ctr_reg, ctr_next;
    logic [NUM_CH-1:0] ch_rst_reg, ch_rst_next;
    logic              running_reg, running_next;
    logic              done_reg, done_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  limit_reg, limit_next;
    logic              limit_hit;
    logic              count_sat;

    reset_sync u_reset_sync (
        .clk         (clk),
        .async_rst_n (reset),
        .sync_rst_n  (rst_sync_n)
    );

    // Current RUN cycle is the last one allowed by a non-zero budget.
    assign limit_hit = (limit_reg != '0) && (count_reg == (limit_reg - 1'b1));
    assign count_sat = &count_reg;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (halt_req)             state_next = ST_DONE;
                else if (ctr_reg == '0)   state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Leaves once the shifted release mask has freed every channel.
                if (halt_req)             state_next = ST_DONE;
                else if (ch_rst_reg == '0) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req || limit_hit) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ctr_next     = ctr_reg;
        ch_rst_next  = ALL_RST;
        count_next   = count_reg;
        limit_next   = limit_reg;
        running_next = (state_next == ST_RUN);
        done_next    = (state_next == ST_DONE);
        case (state_next)
            ST_HOLD: begin
                if (state_reg != ST_HOLD) begin
                    ctr_next   = HOLD_LOAD;
                    count_next = '0;
                    limit_next = cycle_limit;
                end else begin
                    ctr_next = ctr_reg - 1'b1;
                end
            end
            ST_RELEASE: begin
                // The down-counter times each stagger interval; on expiry the
                // mask shifts left, releasing the next channel.
                if (state_reg != ST_RELEASE) begin
                    ch_rst_next = FIRST_REL;
                    ctr_next    = STAG_LOAD;
                end else if (ctr_reg == '0) begin
                    ch_rst_next = ch_rst_reg << 1;
                    ctr_next    = STAG_LOAD;
                end else begin
                    ch_rst_next = ch_rst_reg;
                    ctr_next    = ctr_reg - 1'b1;
                end
            end
            ST_RUN: begin
                ch_rst_next = '0;
            end
            default: ;
        endcase
        // Every RUN cycle is counted, including the one that ends the run.
        if ((state_reg == ST_RUN) && !count_sat) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            ctr_reg     <= '0;
            ch_rst_reg  <= ALL_RST;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
            limit_reg   <= '0;
        end else begin
            ctr_reg     <= ctr_next;
            ch_rst_reg  <= ch_rst_next;
            running_reg <= running_next;
            done_reg    <= done_next;
            count_reg   <= count_next;
            limit_reg   <= limit_next;
        end
    end

    assign ch_rst      = ch_rst_reg;
    assign running     = running_reg;
    assign done        = done_reg;
    assign cycle_count = count_reg;

endmodule

// File: tb/tb_mips_run_controller.sv
// Self-checking bench for mips_run_controller. Three configurations share the
// same stimulus; a timing-rule reference model predicts every cycle's outputs
// into per-instance queues and a negedge monitor compares them.
module tb_mips_run_controller;

    typedef struct packed {
        logic [15:0] ch;
        logic        run;
        logic        dn;
        logic [31:0] cnt;
    } obs_t;

    localparam int NI = 3;

    // Instance 0: defaults. 1: NUM_CH=4 HOLD=2 STAGGER=0 CNT_W=4. 2: NUM_CH=1 HOLD=1 STAGGER=3 CNT_W=8.
    function automatic int p_n(int i); case (i) 0: return 2; 1: return 4; default: return 1; endcase endfunction
    function automatic int p_h(int i); case (i) 0: return 4; 1: return 2; default: return 1; endcase endfunction
    function automatic int p_s(int i); case (i) 0: return 2; 1: return 0; default: return 3; endcase endfunction
    function automatic int p_w(int i); case (i) 0: return 32; 1: return 4; default: return 8; endcase endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] cycle_limit = '0;

    logic [1:0]  ch_a;  logic run_a, done_a; logic [31:0] cnt_a;
    logic [3:0]  ch_b;  logic run_b, done_b; logic [3:0]  cnt_b;
    logic [0:0]  ch_c;  logic run_c, done_c; logic [7:0]  cnt_c;

    always #5 clk = ~clk;

    mips_run_controller dut_a (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .cycle_limit(cycle_limit),
        .ch_rst(ch_a), .running(run_a), .done(done_a), .cycle_count(cnt_a)
    );

    mips_run_controller #(.NUM_CH(4), .HOLD_CYCLES(2), .STAGGER(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .cycle_limit(cycle_limit[3:0]),
        .ch_rst(ch_b), .running(run_b), .done(done_b), .cycle_count(cnt_b)
    );

    mips_run_controller #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER(3), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .cycle_limit(cycle_limit[7:0]),
        .ch_rst(ch_c), .running(run_c), .done(done_c), .cycle_count(cnt_c)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a run is described by t = edges since start was
    // accepted; phase boundaries follow from HOLD, STAGGER and NUM_CH.
    bit     m_active [NI];
    bit     m_fin    [NI];
    int     m_t      [NI];
    longint m_cnt    [NI];
    longint m_lim    [NI];
    int     m_fin_edge [NI];
    int     run_id   [NI];
    int     sync_edges = 0;
    int     edge_no = 0;
    obs_t   q0[$], q1[$], q2[$];

    function automatic logic [15:0] all_ones(int i);
        return 16'((32'd1 << p_n(i)) - 1);
    endfunction

    function automatic obs_t reset_obs(int i);
        obs_t o;
        o = '0;
        o.ch = all_ones(i);
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_active[i] = 1'b0;
            m_fin[i]    = 1'b0;
            m_t[i]      = 0;
            m_cnt[i]    = 0;
            m_lim[i]    = 0;
        end
        q0.delete(); q1.delete(); q2.delete();
        sync_edges = 0;
    endtask

    function automatic obs_t model_out(int i);
        obs_t o;
        int   r;
        o = '0;
        r = (p_n(i) - 1) * p_s(i) + 1;
        o.cnt = 32'(m_cnt[i]);
        if (m_fin[i]) begin
            o.ch = all_ones(i);
            o.dn = 1'b1;
        end else if (!m_active[i] || m_t[i] < p_h(i)) begin
            o.ch = all_ones(i);
        end else if (m_t[i] < p_h(i) + r) begin
            for (int b = 0; b < p_n(i); b++) o.ch[b] = (m_t[i] < p_h(i) + b * p_s(i));
        end else begin
            o.run = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(int i);
        longint maxc;
        int     r;
        bit     in_run;
        maxc = (longint'(1) << p_w(i)) - 1;
        r    = (p_n(i) - 1) * p_s(i) + 1;
        if (!m_active[i]) begin
            if (start) begin
                m_active[i] = 1'b1;
                m_fin[i]    = 1'b0;
                m_t[i]      = 0;
                m_cnt[i]    = 0;
                m_lim[i]    = {32'd0, cycle_limit} & maxc;
            end
        end else begin
            in_run = (m_t[i] >= p_h(i) + r);
            if (in_run && m_cnt[i] < maxc) m_cnt[i]++;
            if (halt_req || (in_run && m_lim[i] != 0 && m_cnt[i] == m_lim[i])) begin
                m_active[i]   = 1'b0;
                m_fin[i]      = 1'b1;
                m_fin_edge[i] = edge_no;
                run_id[i]++;
                $display("dut%0d run %0d ended %s at edge %0d, cycle_count=%0d",
                         i, run_id[i], halt_req ? "by halt" : "at limit", edge_no, m_cnt[i]);
            end else begin
                m_t[i]++;
            end
        end
    endtask

    task automatic push(int i, obs_t o);
        case (i)
            0: q0.push_back(o);
            1: q1.push_back(o);
            default: q2.push_back(o);
        endcase
    endtask

    function automatic bit pop(int i, output obs_t o);
        bit ok;
        ok = 1'b0;
        o  = '0;
        case (i)
            0: if (q0.size() > 0) begin o = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin o = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin o = q2.pop_front(); ok = 1'b1; end
        endcase
        return ok;
    endfunction

    function automatic obs_t dut_obs(int i);
        obs_t o;
        o = '0;
        case (i)
            0: begin o.ch = 16'(ch_a); o.run = run_a; o.dn = done_a; o.cnt = 32'(cnt_a); end
            1: begin o.ch = 16'(ch_b); o.run = run_b; o.dn = done_b; o.cnt = 32'(cnt_b); end
            default: begin o.ch = 16'(ch_c); o.run = run_c; o.dn = done_c; o.cnt = 32'(cnt_c); end
        endcase
        return o;
    endfunction

    task automatic check_obs(int i, obs_t a, obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d cycle@%0t: got ch=%h run=%b done=%b cnt=%0d, want ch=%h run=%b done=%b cnt=%0d",
                     i, $time, a.ch, a.run, a.dn, a.cnt, e.ch, e.run, e.dn, e.cnt);
        end
    endtask

    task automatic check_int(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic fail_timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Model advances on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        edge_no++;
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                if (sync_edges >= 2) model_step(i);
                push(i, model_out(i));
            end
            if (sync_edges < 2) sync_edges++;
        end
    end

    always @(negedge reset) model_reset();

    // Monitor: one comparison per instance per cycle, away from the active edge.
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        bit   have;
        for (int i = 0; i < NI; i++) begin
            a    = dut_obs(i);
            have = 1'b0;
            if (reset) have = pop(i, e);
            if (!have) e = reset_obs(i);
            check_obs(i, a, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_edge;
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (4) tick();

        // Budgeted run: 4 hold + 3 release + 10 run edges.
        cycle_limit = 32'd10;
        start = 1'b1; tick(); start = 1'b0;
        start_edge = edge_no;
        n = 0;
        while (!m_fin[0] && n < 60) begin tick(); n++; end
        if (n >= 60) fail_timeout("limit run done");
        check_int("limit run length", m_fin_edge[0] - start_edge, 17);
        check_int("limit run count", cnt_a, 10);
        check_int("limit run ch_rst", ch_a, 3);
        tick();

        // Unlimited run halted with count 3 in progress.
        cycle_limit = 32'd0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(m_active[0] && m_cnt[0] == 3) && n < 40) begin tick(); n++; end
        if (n >= 40) fail_timeout("reach count 3");
        check_int("count before halt", cnt_a, 3);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check_int("halt run count", cnt_a, 4);
        check_int("halt run done", done_a, 1);
        check_int("halt run ch_rst", ch_a, 3);
        tick();

        // Halt during HOLD.
        start = 1'b1; tick(); start = 1'b0;
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check_int("hold halt done", done_a, 1);
        check_int("hold halt count", cnt_a, 0);
        tick();

        // Halt during RELEASE: channel 0 freed, channel 1 still held.
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(m_active[0] && m_t[0] == 4) && n < 20) begin tick(); n++; end
        if (n >= 20) fail_timeout("reach release");
        check_int("release ch_rst", ch_a, 2);
        check_int("stagger0 ch_rst", ch_b, 0);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check_int("release halt ch_rst", ch_a, 3);
        check_int("release halt done", done_a, 1);
        tick();

        // Saturation on the 4-bit counter, then restart from DONE.
        start = 1'b1; tick(); start = 1'b0;
        repeat (25) tick();
        check_int("saturated count", cnt_b, 15);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check_int("saturated done count", cnt_b, 15);
        start = 1'b1; tick(); start = 1'b0;
        check_int("restart count", cnt_b, 0);
        check_int("restart ch_rst", ch_b, 15);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        tick();

        // Randomised start/halt/limit traffic.
        for (int it = 0; it < 8; it++) begin
            cycle_limit = 32'($urandom_range(0, 20));
            for (int c = 0; c < 40; c++) begin
                start    = ($urandom_range(0, 7) == 0);
                halt_req = ($urandom_range(0, 19) == 0);
                tick();
            end
            start = 1'b0;
            halt_req = 1'b1; tick(); halt_req = 1'b0;
            tick();
        end

        // Asynchronous reset mid-run, with start held across release.
        cycle_limit = 32'd0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        check_int("pre-reset running", run_a, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_int("async ch_rst a", ch_a, 3);
        check_int("async ch_rst b", ch_b, 15);
        check_int("async ch_rst c", ch_c, 1);
        check_int("async running", run_a, 0);
        start = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        check_int("post-reset accepted", m_active[0], 1);
        repeat (3) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
